// File: rtl/mem_arbiter.sv
// Single-port byte-wide RAM controller arbitrating instruction fetch and LSB accesses.
// Define MEM_ARB_RR_EN to alternate grants when both requesters are pending in IDLE.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_TAG = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_is_write,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  input  logic [2:0]        lsb_work_type,
  output logic              lsb_handle,
  output logic              lsb_ready,
  output logic [31:0]       lsb_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic              fetch_q, fetch_d;
  logic [2:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       result_q, result_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        cap_q, cap_d;
  logic [1:0]        ph_q, ph_d;
  logic              ph_v_q, ph_v_d;
  logic              if_rdy_q, if_rdy_d;
  logic              lsb_rdy_q, lsb_rdy_d;
  logic              ld_handle_q, ld_handle_d;
  logic [1:0]        last_beat;
  logic              io_stall;
  logic              sel_lsb;

`ifdef MEM_ARB_RR_EN
  logic last_lsb_q, last_lsb_d;
  assign sel_lsb = lsb_req && (!if_req || !last_lsb_q);
`else
  assign sel_lsb = lsb_req;
`endif

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] d);
    case (t)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'd0, d[7:0]};
      3'b101:  extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Fetches latch type W, so the beat count follows type_q alone.
  always_comb begin
    case (type_q[1:0])
      2'b00:   last_beat = 2'd0;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  end

  assign io_stall = (addr_q[17:16] == IO_TAG) && io_buffer_full;

  always_comb begin
    state_d     = state_q;
    fetch_d     = fetch_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    result_d    = result_q;
    beat_d      = beat_q;
    cap_d       = cap_q;
    if_rdy_d    = 1'b0;
    lsb_rdy_d   = 1'b0;
    ld_handle_d = 1'b0;
    // ph tracks which beat the RAM sampled last cycle, independent of rdy_in.
    ph_d        = beat_q;
    ph_v_d      = (state_q == StRead);
`ifdef MEM_ARB_RR_EN
    last_lsb_d  = last_lsb_q;
`endif
    if (!rdy_in) begin
      if_rdy_d    = if_rdy_q;
      lsb_rdy_d   = lsb_rdy_q;
      ld_handle_d = ld_handle_q;
      // Re-present the oldest uncaptured beat so its data is valid on resume.
      if (state_q == StRead) beat_d = cap_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rob_clear && (lsb_req || if_req)) begin
            beat_d = 2'd0;
            cap_d  = 2'd0;
            data_d = 32'd0;
            if (sel_lsb) begin
              fetch_d     = 1'b0;
              type_d      = lsb_work_type;
              addr_d      = lsb_addr;
              wdata_d     = lsb_wdata;
              state_d     = lsb_is_write ? StWrite : StRead;
              ld_handle_d = !lsb_is_write;
            end else begin
              fetch_d = 1'b1;
              type_d  = 3'b010;
              addr_d  = if_addr;
              state_d = StRead;
            end
`ifdef MEM_ARB_RR_EN
            last_lsb_d = sel_lsb;
`endif
          end
        end
        StRead: begin
          if (rob_clear) begin
            state_d = StIdle;
          end else begin
            if (ph_v_q && (ph_q == cap_q)) begin
              data_d[{cap_q, 3'b000} +: 8] = mem_din;
              if (cap_q == last_beat) begin
                state_d   = StIdle;
                result_d  = fetch_q ? data_d : extend(type_q, data_d);
                if_rdy_d  = fetch_q;
                lsb_rdy_d = !fetch_q;
              end else begin
                cap_d = cap_q + 2'd1;
              end
            end
            if (beat_q != last_beat) beat_d = beat_q + 2'd1;
          end
        end
        StWrite: begin
          if (!io_stall) begin
            if (beat_q == last_beat) state_d = StIdle;
            else                     beat_d  = beat_q + 2'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      fetch_q     <= 1'b0;
      type_q      <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      data_q      <= 32'd0;
      result_q    <= 32'd0;
      beat_q      <= 2'd0;
      cap_q       <= 2'd0;
      ph_q        <= 2'd0;
      ph_v_q      <= 1'b0;
      if_rdy_q    <= 1'b0;
      lsb_rdy_q   <= 1'b0;
      ld_handle_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_lsb_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      result_q    <= result_d;
      beat_q      <= beat_d;
      cap_q       <= cap_d;
      ph_q        <= ph_d;
      ph_v_q      <= ph_v_d;
      if_rdy_q    <= if_rdy_d;
      lsb_rdy_q   <= lsb_rdy_d;
      ld_handle_q <= ld_handle_d;
`ifdef MEM_ARB_RR_EN
      last_lsb_q  <= last_lsb_d;
`endif
    end
  end

  assign mem_a      = addr_q + ADDR_W'(beat_q);
  assign mem_dout   = wdata_q[{beat_q, 3'b000} +: 8];
  assign mem_wr     = (state_q == StWrite) && rdy_in && !io_stall;
  assign lsb_handle = ld_handle_q || (mem_wr && (beat_q == last_beat));
  assign lsb_ready  = lsb_rdy_q && !rob_clear;
  assign if_ready   = if_rdy_q && !rob_clear;
  assign lsb_rdata  = result_q;
  assign if_data    = result_q;

endmodule
